ifetch_ctrl: RTL and testbench



---
 rtl/ifetch_ctrl_pkg.sv | 14 +
 rtl/riscv_pkg.sv | 6 +
 rtl/ifetch_ctrl_if.sv | 27 ++
 rtl/ifetch_pc_fifo.sv | 56 +++++
 rtl/ifetch_ctrl.sv | 136 +++++++++++++
 tb/tb_ifetch_ctrl.sv | 204 ++++++++++++++++++++
 6 files changed

// File: rtl/ifetch_ctrl_pkg.sv
// Fetch-controller types and helpers.
package ifetch_ctrl_pkg;
  import riscv_pkg::*;

  // RUN forwards responses; FLUSH drops responses issued before a redirect.
  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~{{(XLEN-2){1'b0}}, 2'b11};
  endfunction
endpackage

// File: rtl/riscv_pkg.sv
// Core-wide constants shared by the front-end blocks.
package riscv_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned INST_W = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bundle: redirect input, icache request/response, decode output.
interface ifetch_ctrl_if;
  import riscv_pkg::*;

  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [INST_W-1:0] resp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_data;
  logic [XLEN-1:0]   inst_pc;

  modport master (
    input  redirect_valid, redirect_pc, req_ready, resp_valid, resp_data, inst_ready,
    output req_valid, req_addr, resp_ready, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, req_ready, resp_valid, resp_data, inst_ready,
    input  req_valid, req_addr, resp_ready, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/ifetch_pc_fifo.sv
// Small synchronous FIFO holding the PCs of requests still awaiting a response.
module ifetch_pc_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty_o  = (count_q == '0);
    full_o   = (count_q == CNT_W'(DEPTH));
    head_o   = mem_q[rd_ptr_q];
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end
endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch-stage sequencer: issues the PC stream to the icache, squashes stale
// responses after a redirect and hands {inst, pc} to decode via a skid register.
module ifetch_ctrl
  import riscv_pkg::*;
  import ifetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input logic           clk,
  input logic           rstn,
  ifetch_ctrl_if.master bus
);
  localparam int unsigned     CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  kill_q, kill_d;
  logic              inst_valid_q, inst_valid_d;
  logic [INST_W-1:0] inst_data_q, inst_data_d;
  logic [XLEN-1:0]   inst_pc_q, inst_pc_d;

  logic              req_fire, resp_fire, out_fire;
  logic [XLEN-1:0]   fifo_head;
  logic              fifo_empty, fifo_full;

  always_comb begin
    req_fire  = bus.req_valid & bus.req_ready;
    resp_fire = bus.resp_valid & bus.resp_ready;
    out_fire  = bus.inst_valid & bus.inst_ready;
  end

  ifetch_pc_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (req_fire),
    .push_data_i (pc_q),
    .pop_i       (resp_fire),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a redirect re-decides the state from the freshly computed kill count
  always_comb begin
    state_d = state_q;
    if (bus.redirect_valid) begin
      state_d = (kill_d != '0) ? ST_FLUSH : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   state_d = ST_RUN;
        ST_FLUSH: if (resp_fire && kill_q == CNT_W'(1)) state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.req_valid  = !bus.redirect_valid && (outst_q < MAX_CNT);
    bus.req_addr   = pc_q;
    bus.resp_ready = (state_q == ST_FLUSH) ? 1'b1 : (!inst_valid_q | bus.inst_ready);
    bus.inst_valid = inst_valid_q;
    bus.inst_data  = inst_data_q;
    bus.inst_pc    = inst_pc_q;
  end

  // Datapath next values; the redirect branch takes priority over every other update
  always_comb begin
    pc_d         = pc_q;
    outst_d      = outst_q + CNT_W'(req_fire) - CNT_W'(resp_fire);
    kill_d       = kill_q;
    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;

    if (bus.redirect_valid) begin
      pc_d         = align_pc(bus.redirect_pc);
      kill_d       = outst_q - CNT_W'(resp_fire);
      inst_valid_d = 1'b0;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + XLEN'(4);
      end
      if (state_q == ST_FLUSH && resp_fire) begin
        kill_d = kill_q - CNT_W'(1);
      end
      if (state_q == ST_RUN && resp_fire) begin
        inst_valid_d = 1'b1;
        inst_data_d  = bus.resp_data;
        inst_pc_d    = fifo_head;
      end else if (out_fire) begin
        inst_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q         <= RESET_PC;
      outst_q      <= '0;
      kill_q       <= '0;
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      inst_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      outst_q      <= outst_d;
      kill_q       <= kill_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(resp_fire && fifo_empty));
      assert (!(req_fire && fifo_full));
    end
  end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomized and directed bench for ifetch_ctrl against a queue-based fetch model.
module tb_ifetch_ctrl;
  localparam int unsigned MAX_OUT = 2;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  ifetch_ctrl_if bus();

  ifetch_ctrl #(
    .RESET_PC        (RST_PC),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  // Model: next fetch PC, decode output register, and the in-flight requests
  // held by the cache (address, due cycle, whether a later redirect made it stale).
  logic [31:0] m_pc, m_od, m_op;
  bit          m_ov;
  logic [31:0] c_addr [$];
  int unsigned c_due  [$];
  bit          c_stale[$];
  int unsigned lat_min = 1, lat_max = 1;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  function automatic bit exp_req_valid();
    return !bus.redirect_valid && (c_addr.size() < MAX_OUT);
  endfunction

  function automatic bit exp_resp_ready();
    if (c_addr.size() != 0 && c_stale[0]) return 1'b1;
    return !m_ov || bus.inst_ready;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC;
    m_ov = 1'b0;
    m_od = '0;
    m_op = '0;
    c_addr.delete();
    c_due.delete();
    c_stale.delete();
  endtask

  task automatic compare();
    chk("req_valid",  {31'b0, bus.req_valid},  {31'b0, exp_req_valid()});
    chk("req_addr",   bus.req_addr,            m_pc);
    chk("resp_ready", {31'b0, bus.resp_ready}, {31'b0, exp_resp_ready()});
    chk("inst_valid", {31'b0, bus.inst_valid}, {31'b0, m_ov});
    chk("inst_data",  bus.inst_data,           m_od);
    chk("inst_pc",    bus.inst_pc,             m_op);
  endtask

  // One clock: drive at the falling edge, check 1ns later, advance the model at the rising edge.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rq_rdy, input bit in_rdy);
    bit          rf, pf, of, head_stale;
    logic [31:0] head_a;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.req_ready      = rq_rdy;
    bus.inst_ready     = in_rdy;
    if (c_addr.size() != 0 && c_due[0] <= cyc) begin
      bus.resp_valid = 1'b1;
      bus.resp_data  = inst_of(c_addr[0]);
    end else begin
      bus.resp_valid = 1'b0;
      bus.resp_data  = $urandom;
    end
    #1;
    compare();
    rf = exp_req_valid() && rq_rdy;
    pf = bus.resp_valid && exp_resp_ready();
    of = m_ov && in_rdy;
    @(posedge clk);
    cyc++;
    head_stale = 1'b0;
    head_a     = '0;
    if (pf) begin
      head_a     = c_addr.pop_front();
      head_stale = c_stale.pop_front();
      void'(c_due.pop_front());
    end
    if (redir) begin
      m_ov = 1'b0;
      foreach (c_stale[i]) c_stale[i] = 1'b1;
      m_pc = rpc & ~32'h3;
    end else begin
      if (rf) begin
        c_addr.push_back(m_pc);
        c_stale.push_back(1'b0);
        c_due.push_back(cyc + $urandom_range(lat_max, lat_min) - 1);
        m_pc = m_pc + 32'd4;
      end
      if (pf && !head_stale) begin
        m_ov = 1'b1;
        m_od = inst_of(head_a);
        m_op = head_a;
      end else if (of) begin
        m_ov = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rstn               = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.resp_data      = '0;
    bus.inst_ready     = 1'b0;
    model_reset();

    @(negedge clk);
    compare();
    rstn = 1'b1;

    // Streaming with a single-cycle cache
    lat_min = 1; lat_max = 1;
    repeat (24) step(1'b0, '0, 1'b1, 1'b1);

    // Cache refuses requests
    repeat (6) step(1'b0, '0, 1'b0, 1'b1);

    // Slow cache: two accepted, then request gating until a response
    lat_min = 8; lat_max = 8;
    repeat (20) step(1'b0, '0, 1'b1, 1'b1);

    // Decode back-pressure for five cycles
    lat_min = 1; lat_max = 1;
    repeat (4) step(1'b0, '0, 1'b1, 1'b1);
    repeat (5) step(1'b0, '0, 1'b1, 1'b0);
    repeat (6) step(1'b0, '0, 1'b1, 1'b1);

    // Redirect with two requests in flight
    lat_min = 3; lat_max = 3;
    repeat (6) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 32'h0000_1003, 1'b1, 1'b1);
    chk("redir_addr", bus.req_addr, 32'h0000_1000);
    repeat (12) step(1'b0, '0, 1'b1, 1'b1);

    // Redirect coinciding with resp_fire and out_fire, one in flight
    lat_min = 1; lat_max = 1;
    repeat (6) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 32'h0000_2000, 1'b1, 1'b1);
    chk("coinc_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("coinc_resp_ready", {31'b0, bus.resp_ready}, 32'd1);
    chk("coinc_addr", bus.req_addr, 32'h0000_2000);
    repeat (6) step(1'b0, '0, 1'b1, 1'b1);

    // PC wrap at the top of the address space
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("wrap_addr", bus.req_addr, 32'h0000_0000);
    repeat (4) step(1'b0, '0, 1'b1, 1'b1);

    // Random traffic
    lat_min = 1; lat_max = 4;
    repeat (400) step($urandom_range(15, 0) == 0, $urandom,
                      $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);

    // Asynchronous reset while flushing
    lat_min = 6; lat_max = 6;
    repeat (4) step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 32'h0000_3000, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    #3;
    rstn               = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.resp_valid     = 1'b0;
    model_reset();
    #1;
    compare();
    chk("rst_addr", bus.req_addr, RST_PC);
    @(negedge clk);
    rstn = 1'b1;
    lat_min = 1; lat_max = 1;
    repeat (10) step(1'b0, '0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
